pipelined_approx_rc_adder: RTL and testbench

//  Parametrised, pipelined ripple-carry adder with a runtime exact/approximate mode.
//  - Low APPROX_LSBS bit positions use approximate cell AFA43 when approx_en=1.
//  - Upper bits always use exact full adders.
//  - Carry chain split into STAGES registered segments; valid/ready handshake both sides.
//  - Datapath block for the approximate-arithmetic evaluation flow.

---
 rtl/pipelined_approx_rc_adder.sv | 197 +++++++++++++++++++
 tb/tb_pipelined_approx_rc_adder.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_approx_rc_adder.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_approx_rc_adder
// Description : Pipelined ripple-carry adder. A runtime switch (approx_en)
//               selects approximate AFA43 cells for the low APPROX_LSBS bit
//               positions. The carry chain is cut into STAGES registered
//               segments with valid/ready handshakes on both sides.
//               Optional macro APPROX_ERR_MON_EN adds an exact shadow sum
//               and the err_dist / err_cnt error-monitor outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_approx_rc_adder #(
    parameter int WIDTH       = 16,
    parameter int APPROX_LSBS = 5,
    parameter int STAGES      = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             approx_en,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef APPROX_ERR_MON_EN
    output logic [WIDTH:0]   err_dist,
    output logic [15:0]      err_cnt,
`endif
    output logic [WIDTH:0]   out_sum
);

    // Bits resolved per pipeline stage; trailing segments may be short or empty.
    localparam int SEG = (WIDTH + STAGES - 1) / STAGES;

    logic [STAGES-1:0] stage_vld;
    logic [STAGES-1:0] stage_adv;

    // A stage may load when it, or any stage after it, has a free slot,
    // or when the output side is draining this cycle.
    always_comb begin
        stage_adv = '0;
        for (int k = 0; k < STAGES; k++) begin
            stage_adv[k] = out_ready;
            for (int j = k; j < STAGES; j++) begin
                if (!stage_vld[j]) begin
                    stage_adv[k] = 1'b1;
                end
            end
        end
    end

    // Each stage word carries: finished sum bits [HI-1:0], the carry out of
    // bit HI-1, and (except in the last stage) the not-yet-added operand bits
    // packed as {b[WIDTH-1:HI], a[WIDTH-1:HI], approx_en}.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = ((k * SEG) < WIDTH) ? (k * SEG) : WIDTH;
        localparam int HI = (((k + 1) * SEG) < WIDTH) ? ((k + 1) * SEG) : WIDTH;
        localparam int OW = 2 * (WIDTH - LO) + 1;

        logic [OW-1:0] ops_in;
        logic          c_in;
        logic          v_in;
        logic [HI-1:0] low_keep;
        logic [HI-1:0] sum_d;
        logic          c_d;
        logic [HI-1:0] sum_q;
        logic          carry_q;
        logic          vld_q;

        if (k == 0) begin : g_first
            assign ops_in   = {in_b, in_a, approx_en};
            assign c_in     = 1'b0;
            assign v_in     = in_valid;
            assign low_keep = '0;
        end else begin : g_next
            assign ops_in   = g_stage[k-1].g_fwd.ops_q;
            assign c_in     = g_stage[k-1].carry_q;
            assign v_in     = stage_vld[k-1];
            assign low_keep = HI'(g_stage[k-1].sum_q);
        end

        // Ripple this segment, choosing AFA43 or an exact FA per bit position.
        always_comb begin
            logic x;
            logic y;
            x     = 1'b0;
            y     = 1'b0;
            sum_d = low_keep;
            c_d   = c_in;
            for (int i = LO; i < HI; i++) begin
                x = ops_in[1 + i - LO];
                y = ops_in[1 + (WIDTH - LO) + (i - LO)];
                if (ops_in[0] && (i < APPROX_LSBS)) begin
                    sum_d[i] = (~c_d & (x | y)) | (x & y & c_d);
                    c_d      = x & y;
                end else begin
                    sum_d[i] = x ^ y ^ c_d;
                    c_d      = (x & y) | (x & c_d) | (y & c_d);
                end
            end
        end

        // Stage register: take a new beat whenever this slot is allowed to move.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q   <= 1'b0;
                sum_q   <= '0;
                carry_q <= 1'b0;
            end else if (stage_adv[k]) begin
                vld_q <= v_in;
                if (v_in) begin
                    sum_q   <= sum_d;
                    carry_q <= c_d;
                end
            end
        end

        assign stage_vld[k] = vld_q;

        if (k < STAGES - 1) begin : g_fwd
            logic [2*(WIDTH-HI):0] ops_d;
            logic [2*(WIDTH-HI):0] ops_q;

            if (HI < WIDTH) begin : g_ops
                assign ops_d = {ops_in[2*(WIDTH-LO) : (WIDTH-LO)+1+(HI-LO)],
                                ops_in[WIDTH-LO : (HI-LO)+1],
                                ops_in[0]};
            end else begin : g_mode_only
                assign ops_d = ops_in[0];
            end

            // Hand the remaining operand bits and mode to the next segment.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ops_q <= '0;
                end else if (stage_adv[k] && v_in) begin
                    ops_q <= ops_d;
                end
            end
        end

`ifdef APPROX_ERR_MON_EN
        logic [WIDTH:0] ex_in;
        logic [WIDTH:0] ex_q;

        if (k == 0) begin : g_ex_first
            assign ex_in = {1'b0, in_a} + {1'b0, in_b};
        end else begin : g_ex_next
            assign ex_in = g_stage[k-1].ex_q;
        end

        // Exact reference sum travels alongside the beat.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ex_q <= '0;
            end else if (stage_adv[k] && v_in) begin
                ex_q <= ex_in;
            end
        end
`endif
    end

    // Release of rst_n is expected to be synchronous to clk upstream of here.
    assign in_ready  = stage_adv[0];
    assign out_valid = stage_vld[STAGES-1];
    assign out_sum   = {g_stage[STAGES-1].carry_q, g_stage[STAGES-1].sum_q};

`ifdef APPROX_ERR_MON_EN
    logic [WIDTH:0] ex_out;
    logic [15:0]    err_cnt_q;

    assign ex_out = g_stage[STAGES-1].ex_q;

    // Absolute distance between the exact and the delivered sum.
    always_comb begin
        if (ex_out >= out_sum) begin
            err_dist = ex_out - out_sum;
        end else begin
            err_dist = out_sum - ex_out;
        end
    end

    // Count erroneous results as they leave the block, saturating at the top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (out_valid && out_ready && (err_dist != '0) && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipelined_approx_rc_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_approx_rc_adder
// Description : Directed, self-checking bench for pipelined_approx_rc_adder
//               (WIDTH=16, APPROX_LSBS=5, STAGES=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_approx_rc_adder;

    localparam int WIDTH       = 16;
    localparam int APPROX_LSBS = 5;
    localparam int STAGES      = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             approx_en;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   out_sum;
`ifdef APPROX_ERR_MON_EN
    logic [WIDTH:0]   err_dist;
    logic [15:0]      err_cnt;
`endif

    int total = 0;
    int bad   = 0;

    logic [WIDTH:0] exp_q[$];
    logic [WIDTH:0] experr_q[$];

    always #5 clk = ~clk;

    pipelined_approx_rc_adder #(
        .WIDTH       (WIDTH),
        .APPROX_LSBS (APPROX_LSBS),
        .STAGES      (STAGES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .approx_en (approx_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef APPROX_ERR_MON_EN
        .err_dist  (err_dist),
        .err_cnt   (err_cnt),
`endif
        .out_sum   (out_sum)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bit-level reference: whole-width ripple, AFA43 in the low positions when enabled.
    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic ax);
        logic           c;
        logic [WIDTH:0] s;
        c = 1'b0;
        s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (ax && (i < APPROX_LSBS)) begin
                s[i] = (~c & (a[i] | b[i])) | (a[i] & b[i] & c);
                c    = a[i] & b[i];
            end else begin
                s[i] = a[i] ^ b[i] ^ c;
                c    = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
            end
        end
        s[WIDTH] = c;
        return s;
    endfunction

    function automatic logic [WIDTH:0] model_err(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                 input logic ax);
        logic [WIDTH:0] ex;
        logic [WIDTH:0] ap;
        ex = {1'b0, a} + {1'b0, b};
        ap = model(a, b, ax);
        return (ex >= ap) ? (ex - ap) : (ap - ex);
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before the end of the sequence");
        $fatal(1, "watchdog");
    end

    initial begin
        int             sent;
        int             recv;
        int             cyc;
        int             acc;
        logic           took;
        logic [WIDTH:0] e;
        logic [WIDTH:0] held;

        sent = 0; recv = 0; cyc = 0; acc = 0; took = 1'b0; e = '0; held = '0;
        rst_n = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; approx_en = 1'b0; out_ready = 1'b1;

        // ---- 1. reset held, then released
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_hold_out_valid", 32'(out_valid), 32'd0);
        check("rst_hold_out_sum", 32'(out_sum), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_rel_in_ready", 32'(in_ready), 32'd1);
        check("rst_rel_out_valid", 32'(out_valid), 32'd0);
        check("rst_rel_out_sum", 32'(out_sum), 32'd0);
`ifdef APPROX_ERR_MON_EN
        check("rst_rel_err_cnt", 32'(err_cnt), 32'd0);
        check("rst_rel_err_dist", 32'(err_dist), 32'd0);
`endif

        // ---- 2. 0x001F + 0x0001 approximate -> 0x0001D, two-cycle latency
        in_valid = 1'b1; in_a = 16'h001F; in_b = 16'h0001; approx_en = 1'b1;
        check("t2_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_a = '0; in_b = '0; approx_en = 1'b0;
        check("t2_lat1_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("t2_lat2_out_valid", 32'(out_valid), 32'd1);
        check("t2_sum", 32'(out_sum), 32'h0001D);
`ifdef APPROX_ERR_MON_EN
        check("t2_err_dist", 32'(err_dist), 32'd3);
`endif
        @(posedge clk); #1;
        check("t2_drained", 32'(out_valid), 32'd0);
`ifdef APPROX_ERR_MON_EN
        check("t2_err_cnt", 32'(err_cnt), 32'd1);
`endif

        // ---- 3. 0xFFFF + 0x0001 exact then approximate; 0xFFFF + 0xFFFF approximate
        in_valid = 1'b1; in_a = 16'hFFFF; in_b = 16'h0001; approx_en = 1'b0;
        @(posedge clk); #1;
        approx_en = 1'b1;
        @(posedge clk); #1;
        in_b = 16'hFFFF;
        check("t3_exact_valid", 32'(out_valid), 32'd1);
        check("t3_exact_sum", 32'(out_sum), 32'h10000);
`ifdef APPROX_ERR_MON_EN
        check("t3_exact_err", 32'(err_dist), 32'd0);
`endif
        @(posedge clk); #1;
        in_valid = 1'b0; in_a = '0; in_b = '0; approx_en = 1'b0;
        check("t3_approx_sum", 32'(out_sum), 32'h0FFFD);
`ifdef APPROX_ERR_MON_EN
        check("t3_approx_err", 32'(err_dist), 32'd3);
`endif
        @(posedge clk); #1;
        check("t3_ovf_valid", 32'(out_valid), 32'd1);
        check("t3_ovf_sum", 32'(out_sum), 32'h1FFFF);
`ifdef APPROX_ERR_MON_EN
        check("t3_ovf_err", 32'(err_dist), 32'd1);
`endif
        @(posedge clk); #1;
        check("t3_drained", 32'(out_valid), 32'd0);
`ifdef APPROX_ERR_MON_EN
        check("t3_err_cnt", 32'(err_cnt), 32'd3);
`endif

        // ---- 4. 100 random beats, random out_ready, mixed mode
        while (((sent < 100) || (recv < 100)) && (cyc < 4000)) begin
            if ((sent < 100) && ($urandom_range(0, 3) != 0)) begin
                in_valid  = 1'b1;
                in_a      = 16'($urandom);
                in_b      = 16'($urandom);
                approx_en = 1'($urandom_range(0, 1));
            end else begin
                in_valid = 1'b0;
            end
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_a, in_b, approx_en));
                experr_q.push_back(model_err(in_a, in_b, approx_en));
                sent++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("rand_unexpected_result", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("rand_sum", 32'(out_sum), 32'(e));
                    e = experr_q.pop_front();
`ifdef APPROX_ERR_MON_EN
                    check("rand_err_dist", 32'(err_dist), 32'(e));
`endif
                    recv++;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("rand_sent", 32'(sent), 32'd100);
        check("rand_recv", 32'(recv), 32'd100);
        @(posedge clk); #1;
        check("rand_empty_after", 32'(out_valid), 32'd0);

        // ---- 5. stall with continuous input
        out_ready = 1'b0; in_valid = 1'b1; in_a = 16'h1000; in_b = 16'h0234; approx_en = 1'b0;
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            took = in_valid && in_ready;
            if (took) begin
                exp_q.push_back(model(in_a, in_b, approx_en));
                experr_q.push_back(model_err(in_a, in_b, approx_en));
                acc++;
            end
            if (c == 4) begin
                held = out_sum;
            end
            @(posedge clk); #1;
            if (took) begin
                in_a      = 16'h1000 + 16'(acc);
                approx_en = ~approx_en;
            end
        end
        check("stall_accepts", 32'(acc), 32'd2);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        check("stall_out_valid", 32'(out_valid), 32'd1);
        check("stall_sum_stable", 32'(out_sum), 32'(held));
        check("stall_sum_first", 32'(out_sum), 32'h01234);
        in_valid = 1'b0; out_ready = 1'b1;
        recv = 0; cyc = 0;
        while ((recv < 2) && (cyc < 20)) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("drain_unexpected_result", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("drain_sum", 32'(out_sum), 32'(e));
                    e = experr_q.pop_front();
`ifdef APPROX_ERR_MON_EN
                    check("drain_err_dist", 32'(err_dist), 32'(e));
`endif
                    recv++;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        check("drain_count", 32'(recv), 32'd2);
        check("drain_empty", 32'(out_valid), 32'd0);

        // ---- 6. reset with two beats in flight
        in_valid = 1'b1; in_a = 16'h00FF; in_b = 16'h0001; approx_en = 1'b0;
        @(posedge clk); #1;
        in_a = 16'h0F0F; in_b = 16'h0101;
        @(posedge clk); #1;
        in_valid = 1'b0; in_a = '0; in_b = '0;
        check("inflight_valid", 32'(out_valid), 32'd1);
        check("inflight_sum", 32'(out_sum), 32'h00100);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_sum", 32'(out_sum), 32'd0);
`ifdef APPROX_ERR_MON_EN
        check("midrst_err_cnt", 32'(err_cnt), 32'd0);
        check("midrst_err_dist", 32'(err_dist), 32'd0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("postrst_no_stale", 32'(out_valid), 32'd0);
            @(posedge clk); #1;
        end
        check("postrst_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_a = 16'h1234; in_b = 16'h4321; approx_en = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("postrst_valid", 32'(out_valid), 32'd1);
        check("postrst_sum", 32'(out_sum), 32'h05555);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
